fb_draw_writer: RTL and testbench
=================================

FB_DRAW_WRITER -- requirements
Module: fb_draw_writer

Interface
REQ-001 The block SHALL have parameter CORDW, default 16, meaning the signed coordinate width in bits.
REQ-002 The block SHALL have parameter CIDXW, default 4, meaning the colour index width in bits.
REQ-003 The block SHALL have parameter FB_WIDTH, default 320, meaning the framebuffer width in pixels.
REQ-004 The block SHALL have parameter FB_HEIGHT, default 180, meaning the framebuffer height in pixels.
REQ-005 The block SHALL have parameter BG_CIDX, default 0, meaning the clear colour index.
REQ-006 The block SHALL have parameter CLEAR_EN, default 1, meaning clear the framebuffer before each frame when 1.
REQ-007 The block SHALL define local ADDRW = $clog2(FB_WIDTH*FB_HEIGHT).
REQ-008 The block SHALL have ports clk (in, 1), the single clock, and rst_n (in, 1), a synchronous active-low reset.
REQ-009 The block SHALL have ports frame_start (in, 1), a pulse that begins a frame, and draw_en (in, 1), which permits framebuffer writes (e.g. blanking).
REQ-010 The block SHALL have renderer outputs render_rst (out, 1), active-high renderer reset, render_start (out, 1), a renderer start pulse, and oe (out, 1), the renderer output enable.
REQ-011 The block SHALL have renderer inputs x and y (in, CORDW, signed), cidx (in, CIDXW), drawing (in, 1) and render_done (in, 1, level).
REQ-012 The block SHALL have write-port outputs fb_we (out, 1), fb_addr (out, ADDRW) and fb_cidx (out, CIDXW).
REQ-013 The block SHALL have status outputs busy (out, 1), frame_done (out, 1, one-cycle pulse) and clip_cnt (out, 16), the clipped-pixel count for the current frame.

Function
REQ-014 The block SHALL implement states IDLE, CLEAR, RRST, START, DRAW and DONE.
REQ-015 IDLE: on frame_start the block SHALL zero clip_cnt and go to CLEAR if CLEAR_EN=1, otherwise to RRST; busy SHALL be 0 only in IDLE.
REQ-016 CLEAR: the counter SHALL run from 0 to FB_WIDTH*FB_HEIGHT-1 and advance only when draw_en=1; each advancing cycle SHALL register fb_we=1, fb_addr=count and fb_cidx=BG_CIDX.
REQ-017 CLEAR: after the cycle that writes the last address the block SHALL go to RRST.
REQ-018 CLEAR: while draw_en=0 the counter SHALL hold and fb_we SHALL be 0.
REQ-019 RRST SHALL last exactly one cycle with render_rst=1, then go to START.
REQ-020 START SHALL last exactly one cycle with render_start=1, then go to DRAW.
REQ-021 render_rst and render_start SHALL be 0 in all other states.
REQ-022 DRAW: oe SHALL equal draw_en, combinationally; oe SHALL be 0 in all other states.
REQ-023 DRAW: a pixel SHALL be accepted in any cycle with drawing=1.
REQ-024 For an in-bounds accepted pixel (0<=x<FB_WIDTH, 0<=y<FB_HEIGHT) the next cycle SHALL have fb_we=1, fb_addr=y*FB_WIDTH+x (truncated to ADDRW) and fb_cidx=cidx.
REQ-025 Write latency SHALL be exactly 1 cycle.
REQ-026 An out-of-bounds accepted pixel, including any negative coordinate, SHALL produce fb_we=0 and increment clip_cnt, saturating at 16'hFFFF.
REQ-027 The bounds compare SHALL be signed at CORDW bits, and the address multiply SHALL be unsigned after the bounds check passes.
REQ-028 DRAW: when render_done=1 the block SHALL go to DONE; a pixel with drawing=1 in the same cycle SHALL still be written.
REQ-029 DONE SHALL last one cycle with frame_done=1, then go to IDLE.
REQ-030 frame_start outside IDLE SHALL be ignored.
REQ-031 fb_we, fb_addr and fb_cidx SHALL be registered; fb_we SHALL be 0 in every cycle not specified above.

Reset
REQ-032 While rst_n=0 at a clock edge the block SHALL enter IDLE and set fb_we=0, fb_addr=0, fb_cidx=0, clip_cnt=0, frame_done=0, render_start=0, busy=0 and oe=0.
REQ-033 While rst_n=0, render_rst SHALL be 1.
REQ-034 Reset mid-frame SHALL abandon the frame with no further writes and no frame_done pulse.

Verification
REQ-035 Clear: defaults, frame_start, draw_en=1 -> 57600 consecutive writes, addr 0..57599, cidx 0; then render_rst for 1 cycle, then render_start for 1 cycle, then oe=1.
REQ-036 Pixel write: in DRAW, x=10, y=2, cidx=3, drawing=1 -> next cycle fb_we=1, fb_addr=650, fb_cidx=3; x=319, y=179 -> fb_addr=57599.
REQ-037 Clip: pixels (-1,0), (320,5), (5,180) and (0,-1) -> fb_we never 1, clip_cnt=4.
REQ-038 Stall: draw_en=0 for 5 cycles mid-CLEAR -> counter holds and fb_we=0; draw_en=0 in DRAW -> oe=0.
REQ-039 Completion: render_done=1 with drawing=1 at (1,1) -> write to addr 321, next cycle frame_done=1 for 1 cycle, then busy=0; a frame_start during DRAW has no effect.
REQ-040 Reset: rst_n=0 at CLEAR count 1000 -> next cycle fb_we=0, busy=0, render_rst=1, no frame_done pulse.

Source files
------------

// File: rtl/fb_draw_writer.sv
// Framebuffer draw writer: optionally clears the framebuffer, sequences the
// renderer through reset/start, then turns renderer pixels into clipped,
// one-cycle-latency framebuffer writes until the renderer reports done.
module fb_draw_writer #(
  parameter int CORDW     = 16,
  parameter int CIDXW     = 4,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180,
  parameter int BG_CIDX   = 0,
  parameter int CLEAR_EN  = 1,
  localparam int ADDRW    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    draw_en,
  output logic                    render_rst,
  output logic                    render_start,
  output logic                    oe,
  input  logic signed [CORDW-1:0] x,
  input  logic signed [CORDW-1:0] y,
  input  logic        [CIDXW-1:0] cidx,
  input  logic                    drawing,
  input  logic                    render_done,
  output logic                    fb_we,
  output logic        [ADDRW-1:0] fb_addr,
  output logic        [CIDXW-1:0] fb_cidx,
  output logic                    busy,
  output logic                    frame_done,
  output logic             [15:0] clip_cnt
);

  localparam int PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam logic        [ADDRW-1:0] LastAddr = ADDRW'(PIXELS - 1);
  localparam logic signed [CORDW-1:0] XLim     = CORDW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] YLim     = CORDW'(FB_HEIGHT);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRrst,
    StStart,
    StDraw,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] clr_cnt_q, clr_cnt_d;
  logic             fb_we_q, fb_we_d;
  logic [ADDRW-1:0] fb_addr_q, fb_addr_d;
  logic [CIDXW-1:0] fb_cidx_q, fb_cidx_d;
  logic [15:0]      clip_cnt_q, clip_cnt_d;

  logic             in_bounds;
  logic [ADDRW-1:0] pix_addr;

  // Signed compares so negative coordinates fail; address math is only used once in bounds.
  always_comb begin
    in_bounds = !x[CORDW-1] && (x < XLim) && !y[CORDW-1] && (y < YLim);
    pix_addr  = ADDRW'(32'($unsigned(y)) * 32'(FB_WIDTH) + 32'($unsigned(x)));
  end

  // Next-state and write-port logic; fb_we defaults low every cycle.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_cidx_d  = fb_cidx_q;
    clip_cnt_d = clip_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          clip_cnt_d = '0;
          clr_cnt_d  = '0;
          state_d    = (CLEAR_EN != 0) ? StClear : StRrst;
        end
      end
      StClear: begin
        if (draw_en) begin
          fb_we_d   = 1'b1;
          fb_addr_d = clr_cnt_q;
          fb_cidx_d = CIDXW'(BG_CIDX);
          if (clr_cnt_q == LastAddr) begin
            state_d = StRrst;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      StRrst:  state_d = StStart;
      StStart: state_d = StDraw;
      StDraw: begin
        if (drawing) begin
          if (in_bounds) begin
            fb_we_d   = 1'b1;
            fb_addr_d = pix_addr;
            fb_cidx_d = cidx;
          end else if (clip_cnt_q != 16'hFFFF) begin
            clip_cnt_d = clip_cnt_q + 16'd1;
          end
        end
        // A pixel presented alongside render_done is still written above.
        if (render_done) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and registered write port, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      clr_cnt_q  <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_cidx_q  <= '0;
      clip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_cidx_q  <= fb_cidx_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  // Status and renderer controls decoded from the state register; the renderer
  // is also held in reset for as long as rst_n is low.
  always_comb begin
    busy         = (state_q != StIdle);
    render_rst   = !rst_n || (state_q == StRrst);
    render_start = (state_q == StStart);
    frame_done   = (state_q == StDone);
    oe           = (state_q == StDraw) && draw_en;
    fb_we        = fb_we_q;
    fb_addr      = fb_addr_q;
    fb_cidx      = fb_cidx_q;
    clip_cnt     = clip_cnt_q;
  end

endmodule

// File: tb/tb_fb_draw_writer.sv
// Bench for fb_draw_writer: full clear with a stall, directed and randomized
// pixels against an arithmetic framebuffer model, completion and mid-clear reset.
module tb_fb_draw_writer;

  localparam int CORDW = 16;
  localparam int CIDXW = 4;
  localparam int W     = 320;
  localparam int H     = 180;
  localparam int ADDRW = $clog2(W * H);

  logic                    clk = 1'b0;
  logic                    rst_n, frame_start, draw_en;
  logic                    render_rst, render_start, oe;
  logic signed [CORDW-1:0] x, y;
  logic        [CIDXW-1:0] cidx;
  logic                    drawing, render_done;
  logic                    fb_we;
  logic        [ADDRW-1:0] fb_addr;
  logic        [CIDXW-1:0] fb_cidx;
  logic                    busy, frame_done;
  logic             [15:0] clip_cnt;

  always #5 clk = ~clk;

  fb_draw_writer #(
    .CORDW    (CORDW),
    .CIDXW    (CIDXW),
    .FB_WIDTH (W),
    .FB_HEIGHT(H),
    .BG_CIDX  (0),
    .CLEAR_EN (1)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .draw_en     (draw_en),
    .render_rst  (render_rst),
    .render_start(render_start),
    .oe          (oe),
    .x           (x),
    .y           (y),
    .cidx        (cidx),
    .drawing     (drawing),
    .render_done (render_done),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_cidx     (fb_cidx),
    .busy        (busy),
    .frame_done  (frame_done),
    .clip_cnt    (clip_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int px, input int py, input int pc, input bit d);
    x       = CORDW'(px);
    y       = CORDW'(py);
    cidx    = CIDXW'(pc);
    drawing = d;
  endtask

  task automatic expect_write(input string tag, input bit we, input int addr, input int c);
    check_eq({tag, "_we"}, 32'(fb_we), 32'(we));
    if (we) begin
      check_eq({tag, "_addr"}, 32'(fb_addr), 32'(addr));
      check_eq({tag, "_cidx"}, 32'(fb_cidx), 32'(c));
    end
  endtask

  // Model state
  int  exp_addr, errs, cyc, stall_seen, we_acc, exp_clip, fd_acc, busy_acc;
  int  px, py, pc;
  bit  d, en, en_prev, inb, found;
  int  clip_x[4] = '{-1, 320, 5, 0};
  int  clip_y[4] = '{0, 5, 180, -1};

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; draw_en = 1'b1; render_done = 1'b0;
    set_pix(0, 0, 0, 1'b0);
    repeat (3) tick();
    check_eq("rst_we", 32'(fb_we), 0);
    check_eq("rst_addr", 32'(fb_addr), 0);
    check_eq("rst_cidx", 32'(fb_cidx), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_render_rst", 32'(render_rst), 1);
    check_eq("rst_render_start", 32'(render_start), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_oe", 32'(oe), 0);
    check_eq("rst_clip", 32'(clip_cnt), 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("idle_render_rst", 32'(render_rst), 0);

    // Frame 1: full clear with a 5-cycle stall in the middle.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_eq("clear_busy", 32'(busy), 1);
    check_eq("clear_first_we", 32'(fb_we), 0);
    exp_addr = 0; errs = 0; cyc = 0; stall_seen = 0;
    while (exp_addr < W * H && cyc < 60000) begin
      draw_en = !(cyc >= 20000 && cyc < 20005);
      en_prev = draw_en;
      tick();
      cyc++;
      if (en_prev) begin
        if (!(fb_we === 1'b1 && 32'(fb_addr) == exp_addr && fb_cidx == 0)) errs++;
        exp_addr++;
      end else begin
        if (fb_we !== 1'b0) errs++;
        stall_seen++;
      end
    end
    check_eq("clear_seq_errs", 32'(errs), 0);
    check_eq("clear_count", 32'(exp_addr), 32'(W * H));
    check_eq("clear_stall_cycles", 32'(stall_seen), 5);
    check_eq("rrst_render_rst", 32'(render_rst), 1);
    check_eq("rrst_render_start", 32'(render_start), 0);
    check_eq("rrst_oe", 32'(oe), 0);
    tick();
    check_eq("start_we", 32'(fb_we), 0);
    check_eq("start_render_start", 32'(render_start), 1);
    check_eq("start_render_rst", 32'(render_rst), 0);
    tick();
    check_eq("draw_oe", 32'(oe), 1);
    check_eq("draw_render_start", 32'(render_start), 0);
    draw_en = 1'b0;
    #1;
    check_eq("draw_oe_blank", 32'(oe), 0);
    draw_en = 1'b1;

    // Directed pixels
    set_pix(10, 2, 3, 1'b1);
    tick();
    set_pix(319, 179, 7, 1'b1);
    expect_write("pix_10_2", 1'b1, 650, 3);
    tick();
    drawing = 1'b0;
    expect_write("pix_319_179", 1'b1, 57599, 7);

    // Clipped pixels
    we_acc = 0;
    for (int i = 0; i < 4; i++) begin
      set_pix(clip_x[i], clip_y[i], 9, 1'b1);
      tick();
      we_acc += int'(fb_we);
    end
    drawing = 1'b0;
    tick();
    we_acc += int'(fb_we);
    check_eq("clip_we", 32'(we_acc), 0);
    check_eq("clip_cnt4", 32'(clip_cnt), 4);

    // frame_start mid-frame is ignored
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_eq("ignore_fs_busy", 32'(busy), 1);
    check_eq("ignore_fs_oe", 32'(oe), 1);
    check_eq("ignore_fs_clip", 32'(clip_cnt), 4);

    // Randomized pixels against the bounds/address model
    exp_clip = 4;
    repeat (300) begin
      px = int'($urandom_range(359, 0)) - 20;
      py = int'($urandom_range(219, 0)) - 20;
      pc = int'($urandom_range(15, 0));
      d  = ($urandom_range(3, 0) != 0);
      en = ($urandom_range(4, 0) != 0);
      set_pix(px, py, pc, d);
      draw_en = en;
      #1;
      check_eq("rand_oe", 32'(oe), 32'(en));
      tick();
      inb = (px >= 0) && (px < W) && (py >= 0) && (py < H);
      expect_write("rand_pix", d && inb, py * W + px, pc);
      if (d && !inb) exp_clip++;
    end
    drawing = 1'b0;
    draw_en = 1'b1;
    check_eq("rand_clip_cnt", 32'(clip_cnt), 32'(exp_clip));

    // Completion with a last pixel
    set_pix(1, 1, 5, 1'b1);
    render_done = 1'b1;
    tick();
    render_done = 1'b0;
    drawing = 1'b0;
    expect_write("done_pix", 1'b1, 321, 5);
    check_eq("done_frame_done", 32'(frame_done), 1);
    check_eq("done_busy", 32'(busy), 1);
    check_eq("done_oe", 32'(oe), 0);
    tick();
    check_eq("after_frame_done", 32'(frame_done), 0);
    check_eq("after_busy", 32'(busy), 0);
    check_eq("after_we", 32'(fb_we), 0);

    // Frame 2: reset while the clear counter sits at 1000
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_eq("f2_clip_zeroed", 32'(clip_cnt), 0);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (fb_we === 1'b1 && fb_addr == 999) found = 1'b1;
    end
    check_eq("f2_reach_999", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_low_render_rst", 32'(render_rst), 1);
    tick();
    check_eq("midrst_we", 32'(fb_we), 0);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_render_rst", 32'(render_rst), 1);
    check_eq("midrst_addr", 32'(fb_addr), 0);
    rst_n = 1'b1;
    we_acc = 0; fd_acc = 0; busy_acc = 0;
    repeat (50) begin
      tick();
      we_acc   += int'(fb_we);
      fd_acc   += int'(frame_done);
      busy_acc += int'(busy);
    end
    check_eq("post_rst_writes", 32'(we_acc), 0);
    check_eq("post_rst_frame_done", 32'(fd_acc), 0);
    check_eq("post_rst_busy", 32'(busy_acc), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
